// File: rtl/control_dos_digitos_if.sv
// rtl/control_dos_digitos_if.sv - digit entry / comparator / verdict bundle
// master = keypad source plus comparator side, slave = the sequencing controller.
interface control_dos_digitos_if #(
  parameter int ANCHO_CONTADOR = 8
);
  logic [3:0]                digito;
  logic                      digito_valido;
  logic                      borrar;
  logic                      mayor_que_63;
  logic [6:0]                valor;
  logic                      listo;
  logic                      resultado;
  logic                      error_digito;
  logic                      error_timeout;
  logic                      esperando_unidades;
  logic [ANCHO_CONTADOR-1:0] contador_mayores;

  modport master (
    output digito, digito_valido, borrar, mayor_que_63,
    input  valor, listo, resultado, error_digito, error_timeout,
           esperando_unidades, contador_mayores
  );

  modport slave (
    input  digito, digito_valido, borrar, mayor_que_63,
    output valor, listo, resultado, error_digito, error_timeout,
           esperando_unidades, contador_mayores
  );
endinterface

// File: rtl/control_dos_digitos.sv
// rtl/control_dos_digitos.sv - two-digit decimal entry sequencer for the >63 comparator
// Builds tens*10+units, waits one settle cycle, then latches and counts the verdict.
module control_dos_digitos #(
  parameter int TIMEOUT_CICLOS = 1000,
  parameter int ANCHO_CONTADOR = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  control_dos_digitos_if.slave   bus
);

  typedef enum logic [1:0] {
    ESPERA_DECENAS,
    ESPERA_UNIDADES,
    EVALUA,
    REPORTA
  } estado_t;

  localparam logic [15:0] LIMITE = 16'(TIMEOUT_CICLOS - 1);

  estado_t                   estado_q, estado_d;
  logic [3:0]                decenas_q, decenas_d;
  logic [6:0]                valor_q, valor_d;
  logic [15:0]               timer_q, timer_d;
  logic                      listo_q, listo_d;
  logic                      resultado_q, resultado_d;
  logic                      err_dig_q, err_dig_d;
  logic                      err_to_q, err_to_d;
  logic [ANCHO_CONTADOR-1:0] cont_q, cont_d;
  logic                      digito_ok;

  assign digito_ok = (bus.digito <= 4'd9);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q    <= ESPERA_DECENAS;
      decenas_q   <= '0;
      valor_q     <= '0;
      timer_q     <= '0;
      listo_q     <= 1'b0;
      resultado_q <= 1'b0;
      err_dig_q   <= 1'b0;
      err_to_q    <= 1'b0;
      cont_q      <= '0;
    end else begin
      estado_q    <= estado_d;
      decenas_q   <= decenas_d;
      valor_q     <= valor_d;
      timer_q     <= timer_d;
      listo_q     <= listo_d;
      resultado_q <= resultado_d;
      err_dig_q   <= err_dig_d;
      err_to_q    <= err_to_d;
      cont_q      <= cont_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    decenas_d   = decenas_q;
    valor_d     = valor_q;
    timer_d     = timer_q;
    listo_d     = 1'b0;
    resultado_d = resultado_q;
    err_dig_d   = 1'b0;
    err_to_d    = 1'b0;
    cont_d      = cont_q;

    if (bus.borrar) begin
      estado_d = ESPERA_DECENAS;
      timer_d  = '0;
    end else begin
      unique case (estado_q)
        ESPERA_DECENAS: begin
          if (bus.digito_valido) begin
            if (digito_ok) begin
              decenas_d = bus.digito;
              timer_d   = '0;
              estado_d  = ESPERA_UNIDADES;
            end else begin
              err_dig_d = 1'b1;
            end
          end
        end
        ESPERA_UNIDADES: begin
          // A good units digit beats expiry; a bad one arriving at expiry is swallowed by the timeout.
          if (bus.digito_valido && digito_ok) begin
            valor_d  = 7'(decenas_q) * 7'd10 + 7'(bus.digito);
            estado_d = EVALUA;
          end else if (timer_q == LIMITE) begin
            err_to_d = 1'b1;
            timer_d  = '0;
            estado_d = ESPERA_DECENAS;
          end else begin
            timer_d   = timer_q + 16'd1;
            err_dig_d = bus.digito_valido;
          end
        end
        EVALUA: begin
          // Verdict is latched here so listo and resultado appear together in REPORTA.
          estado_d    = REPORTA;
          listo_d     = 1'b1;
          resultado_d = bus.mayor_que_63;
          if (bus.mayor_que_63 && (cont_q != '1)) begin
            cont_d = cont_q + ANCHO_CONTADOR'(1);
          end
        end
        REPORTA: begin
          estado_d = ESPERA_DECENAS;
        end
        default: begin
          estado_d = ESPERA_DECENAS;
        end
      endcase
    end
  end

  assign bus.valor              = valor_q;
  assign bus.listo              = listo_q;
  assign bus.resultado          = resultado_q;
  assign bus.error_digito       = err_dig_q;
  assign bus.error_timeout      = err_to_q;
  assign bus.esperando_unidades = (estado_q == ESPERA_UNIDADES);
  assign bus.contador_mayores   = cont_q;

endmodule

// File: tb/tb_control_dos_digitos.sv
// tb/tb_control_dos_digitos.sv - self-checking bench for control_dos_digitos
// Expected values come from decimal arithmetic on the entered digits.
module tb_control_dos_digitos;
  localparam int TO = 20;
  localparam int W  = 8;
  localparam int CMAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_dos_digitos_if #(.ANCHO_CONTADOR(W)) bus ();
  assign bus.mayor_que_63 = (bus.valor > 7'd63);

  control_dos_digitos #(.TIMEOUT_CICLOS(TO), .ANCHO_CONTADOR(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt   = 0;
  int m_valor = 0;
  int m_res   = 0;

  always @(negedge clk) begin
    if (!reset) begin
      n_tests++;
      if (int'(bus.listo) + int'(bus.error_digito) + int'(bus.error_timeout) > 1) begin
        n_fail++;
        $display("FAIL strobe_overlap listo=%0b err_dig=%0b err_to=%0b need at most one",
                 bus.listo, bus.error_digito, bus.error_timeout);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_digit(input int d);
    bus.digito        = 4'(d);
    bus.digito_valido = 1'b1;
    tick();
    bus.digito_valido = 1'b0;
  endtask

  task automatic finish_units(input int t, input int u);
    put_digit(u);
    m_valor = 10 * t + u;
    m_res   = (m_valor > 63) ? 1 : 0;
    if (m_res == 1 && m_cnt < CMAX) m_cnt++;
    n_tests++;
    if (int'(bus.valor) !== m_valor || bus.listo !== 1'b0 || bus.error_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL units_accept valor=%0d listo=%0b err_to=%0b need valor=%0d listo=0 err_to=0",
               bus.valor, bus.listo, bus.error_timeout, m_valor);
    end
    tick();
    n_tests++;
    if (bus.listo !== 1'b1 || int'(bus.resultado) !== m_res || int'(bus.contador_mayores) !== m_cnt) begin
      n_fail++;
      $display("FAIL report listo=%0b res=%0b cnt=%0d need listo=1 res=%0d cnt=%0d",
               bus.listo, bus.resultado, bus.contador_mayores, m_res, m_cnt);
    end
    tick();
    n_tests++;
    if (bus.listo !== 1'b0 || bus.esperando_unidades !== 1'b0) begin
      n_fail++;
      $display("FAIL after_report listo=%0b esp=%0b need 0 0", bus.listo, bus.esperando_unidades);
    end
  endtask

  task automatic do_entry(input int t, input int u);
    put_digit(t);
    n_tests++;
    if (bus.esperando_unidades !== 1'b1) begin
      n_fail++;
      $display("FAIL tens_accept esp=%0b need 1 (tens=%0d)", bus.esperando_unidades, t);
    end
    finish_units(t, u);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.digito = 4'd0; bus.digito_valido = 1'b0; bus.borrar = 1'b0;
    tick(); tick();
    n_tests++;
    if (bus.valor !== 7'd0 || bus.listo !== 1'b0 || bus.resultado !== 1'b0 ||
        bus.error_digito !== 1'b0 || bus.error_timeout !== 1'b0 ||
        bus.esperando_unidades !== 1'b0 || bus.contador_mayores !== '0) begin
      n_fail++;
      $display("FAIL reset_state valor=%0d listo=%0b res=%0b cnt=%0d esp=%0b need all zero",
               bus.valor, bus.listo, bus.resultado, bus.contador_mayores, bus.esperando_unidades);
    end
    reset = 1'b0;
    m_cnt = 0; m_valor = 0; m_res = 0;
    tick();
  endtask

  task automatic test_boundaries();
    do_entry(6, 3);
    do_entry(6, 4);
    do_entry(9, 9);
    n_tests++;
    if (int'(bus.contador_mayores) !== 2) begin
      n_fail++;
      $display("FAIL count_after_64_99 cnt=%0d need 2", bus.contador_mayores);
    end
    do_entry(0, 0);
  endtask

  task automatic test_invalid_digits();
    put_digit(12);
    n_tests++;
    if (bus.error_digito !== 1'b1 || bus.esperando_unidades !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_tens err_dig=%0b esp=%0b need 1 0", bus.error_digito, bus.esperando_unidades);
    end
    tick();
    n_tests++;
    if (bus.error_digito !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_tens_pulse err_dig=%0b need 0", bus.error_digito);
    end
    put_digit(7);
    put_digit(15);
    n_tests++;
    if (bus.error_digito !== 1'b1 || bus.esperando_unidades !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_units err_dig=%0b esp=%0b need 1 1", bus.error_digito, bus.esperando_unidades);
    end
    finish_units(7, 1);
  endtask

  task automatic test_timeout();
    put_digit(5);
    repeat (TO - 1) tick();
    n_tests++;
    if (bus.error_timeout !== 1'b0 || bus.esperando_unidades !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_expiry err_to=%0b esp=%0b need 0 1", bus.error_timeout, bus.esperando_unidades);
    end
    tick();
    n_tests++;
    if (bus.error_timeout !== 1'b1 || bus.esperando_unidades !== 1'b0 ||
        bus.listo !== 1'b0 || int'(bus.valor) !== m_valor) begin
      n_fail++;
      $display("FAIL expiry err_to=%0b esp=%0b listo=%0b valor=%0d need 1 0 0 %0d",
               bus.error_timeout, bus.esperando_unidades, bus.listo, bus.valor, m_valor);
    end
    tick();
    n_tests++;
    if (bus.error_timeout !== 1'b0 || bus.listo !== 1'b0) begin
      n_fail++;
      $display("FAIL expiry_pulse err_to=%0b listo=%0b need 0 0", bus.error_timeout, bus.listo);
    end
    put_digit(5);
    repeat (TO - 1) tick();
    finish_units(5, 2);
  endtask

  task automatic test_async_reset_and_borrar();
    do_entry(8, 8);
    put_digit(8);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (bus.valor !== 7'd0 || bus.contador_mayores !== '0 || bus.resultado !== 1'b0 ||
        bus.esperando_unidades !== 1'b0 || bus.listo !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset valor=%0d cnt=%0d res=%0b esp=%0b need all zero",
               bus.valor, bus.contador_mayores, bus.resultado, bus.esperando_unidades);
    end
    m_cnt = 0; m_valor = 0; m_res = 0;
    tick();
    reset = 1'b0;
    tick();
    do_entry(7, 0);
    put_digit(3);
    bus.digito = 4'd4; bus.digito_valido = 1'b1; bus.borrar = 1'b1;
    tick();
    bus.digito_valido = 1'b0; bus.borrar = 1'b0;
    n_tests++;
    if (bus.esperando_unidades !== 1'b0 || int'(bus.valor) !== m_valor) begin
      n_fail++;
      $display("FAIL borrar esp=%0b valor=%0d need 0 %0d", bus.esperando_unidades, bus.valor, m_valor);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (bus.listo !== 1'b0 || int'(bus.resultado) !== m_res || int'(bus.contador_mayores) !== m_cnt) begin
        n_fail++;
        $display("FAIL borrar_quiet listo=%0b res=%0b cnt=%0d need 0 %0d %0d",
                 bus.listo, bus.resultado, bus.contador_mayores, m_res, m_cnt);
      end
    end
  endtask

  task automatic test_random();
    int t, u, gap;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        put_digit($urandom_range(10, 15));
        n_tests++;
        if (bus.error_digito !== 1'b1 || bus.esperando_unidades !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_bad_tens err_dig=%0b esp=%0b need 1 0", bus.error_digito, bus.esperando_unidades);
        end
      end
      t = $urandom_range(0, 9);
      u = $urandom_range(0, 9);
      put_digit(t);
      gap = $urandom_range(0, TO - 4);
      repeat (gap) tick();
      if ($urandom_range(0, 2) == 0) begin
        put_digit($urandom_range(10, 15));
        n_tests++;
        if (bus.error_digito !== 1'b1 || bus.esperando_unidades !== 1'b1) begin
          n_fail++;
          $display("FAIL rnd_bad_units err_dig=%0b esp=%0b need 1 1", bus.error_digito, bus.esperando_unidades);
        end
      end
      finish_units(t, u);
    end
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_cnt = 0; m_valor = 0; m_res = 0;
    tick();
    for (int k = 0; k < 300; k++) do_entry(9, 9);
    n_tests++;
    if (int'(bus.contador_mayores) !== CMAX) begin
      n_fail++;
      $display("FAIL saturation cnt=%0d need %0d", bus.contador_mayores, CMAX);
    end
  endtask

  initial begin
    bus.digito = 4'd0;
    bus.digito_valido = 1'b0;
    bus.borrar = 1'b0;
    reset = 1'b1;
    test_reset();
    test_boundaries();
    test_invalid_digits();
    test_timeout();
    test_async_reset_and_borrar();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
